seq_shift_rot_unit: RTL and testbench

Parametrised multi-cycle shift/rotate unit for the ALU datapath. It succeeds the combinational rotate-right block and adds:
- rotate left/right, logical shift left/right and arithmetic shift right
- iterative shifting of STEP positions per clock
- start/busy/done handshake
- a true carry flag

The result is driven onto the shared bus as {N,Z,C,V,result}, tri-stated when not enabled.

---
 rtl/seq_shift_rot_unit_if.sv | 18 +
 rtl/seq_shift_rot_unit.sv | 189 ++++++++++++++++++
 tb/tb_seq_shift_rot_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_rot_unit_if.sv
// Request/status bundle for the sequential shift/rotate unit.
// Latency: none, wires only.
// Backpressure: start is only honoured while busy is low.
interface seq_shift_rot_unit_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   s_value;
    logic             busy;
    logic             done;

    modport master (output start, op, din, s_value, input busy, done);
    modport slave  (input start, op, din, s_value, output busy, done);
endinterface

// File: rtl/seq_shift_rot_unit.sv
// Iterative shift/rotate unit: up to STEP positions per clock, result and N/Z/C/V flags onto a tri-state bus.
// Latency: done at T+1+ceil(s_value/STEP) after start is accepted at T.
// Backpressure: start is ignored while busy (RUN/DONE), no queuing; out floats when enbit=0.
module seq_shift_rot_unit #(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    seq_shift_rot_unit_if.slave ctl,
    input  logic                enbit,
    output wire  [WIDTH+3:0]    out
);

    // One extra bit so a per-cycle step equal to WIDTH is representable.
    localparam int KW = SHW + 1;

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SAR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] din_q;
    logic [2:0]       op_q;
    logic [SHW-1:0]   sval_q;
    logic [SHW-1:0]   rem_q;
    logic             n_q;
    logic             z_q;
    logic             c_q;
    logic             v_q;

    logic [KW-1:0]    k;
    logic [SHW-1:0]   rem_next;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] sar_mask;

    logic [2:0]       fl_op;
    logic [WIDTH-1:0] fl_din;
    logic [SHW-1:0]   fl_sv;
    logic [WIDTH-1:0] fl_res;
    logic [SHW-1:0]   idx_lo;
    logic [SHW-1:0]   idx_hi;
    logic             fl_n;
    logic             fl_z;
    logic             fl_c;
    logic             fl_v;

    // One iteration of the working register: move k=min(rem,STEP) positions.
    always_comb begin
        k        = ({1'b0, rem_q} < KW'(STEP)) ? {1'b0, rem_q} : KW'(STEP);
        rem_next = rem_q - k[SHW-1:0];
        sar_mask = ~({WIDTH{1'b1}} >> k);
        w_step   = w_q;
        case (op_q)
            OP_ROR:  w_step = (w_q >> k) | (w_q << (KW'(WIDTH) - k));
            OP_ROL:  w_step = (w_q << k) | (w_q >> (KW'(WIDTH) - k));
            OP_SHR:  w_step = w_q >> k;
            OP_SHL:  w_step = w_q << k;
            OP_SAR:  w_step = (w_q >> k) | (din_q[WIDTH-1] ? sar_mask : '0);
            default: w_step = w_q;
        endcase
    end

    // Flags for the value about to enter DONE; a zero-amount start takes them straight from the inputs.
    always_comb begin
        fl_op  = op_q;
        fl_din = din_q;
        fl_sv  = sval_q;
        fl_res = w_step;
        if (state_q == ST_IDLE) begin
            fl_op  = ctl.op;
            fl_din = ctl.din;
            fl_sv  = ctl.s_value;
            fl_res = ctl.din;
        end
        // idx_hi wraps to WIDTH-s_value because WIDTH is a power of two.
        idx_lo = fl_sv - SHW'(1);
        idx_hi = SHW'(0) - fl_sv;
        fl_n   = fl_res[WIDTH-1];
        fl_z   = (fl_res == '0);
        fl_v   = (fl_op == OP_SHL) && (fl_res[WIDTH-1] != fl_din[WIDTH-1]);
        fl_c   = 1'b0;
        if (fl_sv != '0) begin
            case (fl_op)
                OP_ROR:  fl_c = fl_res[WIDTH-1];
                OP_ROL:  fl_c = fl_res[0];
                OP_SHR:  fl_c = fl_din[idx_lo];
                OP_SAR:  fl_c = fl_din[idx_lo];
                OP_SHL:  fl_c = fl_din[idx_hi];
                default: fl_c = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-amount requests skip RUN entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    state_d = (ctl.s_value == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, iterative shifting and flag registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q    <= '0;
            din_q  <= '0;
            op_q   <= '0;
            sval_q <= '0;
            rem_q  <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl.start) begin
                        w_q    <= ctl.din;
                        din_q  <= ctl.din;
                        op_q   <= ctl.op;
                        sval_q <= ctl.s_value;
                        rem_q  <= ctl.s_value;
                        c_q    <= 1'b0;
                        if (ctl.s_value == '0) begin
                            n_q <= fl_n;
                            z_q <= fl_z;
                            v_q <= fl_v;
                        end else begin
                            n_q <= 1'b0;
                            z_q <= 1'b0;
                            v_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    w_q   <= w_step;
                    rem_q <= rem_next;
                    if (rem_next == '0) begin
                        n_q <= fl_n;
                        z_q <= fl_z;
                        c_q <= fl_c;
                        v_q <= fl_v;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ctl.busy = (state_q != ST_IDLE);
    assign ctl.done = (state_q == ST_DONE);

    // Shared-bus driver; released entirely when not enabled.
    assign out = enbit ? {n_q, z_q, c_q, v_q, w_q} : {(WIDTH + 4){1'bz}};

endmodule

// File: tb/tb_seq_shift_rot_unit.sv
module tb_seq_shift_rot_unit;

    logic clk;
    logic reset;
    logic en1;
    logic en4;
    tri1 [35:0] out1;
    tri1 [35:0] out4;

    int errors;
    int checks;

    seq_shift_rot_unit_if #(.WIDTH(32)) if1 ();
    seq_shift_rot_unit_if #(.WIDTH(32)) if4 ();

    seq_shift_rot_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk   (clk),
        .reset (reset),
        .ctl   (if1.slave),
        .enbit (en1),
        .out   (out1)
    );

    seq_shift_rot_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk   (clk),
        .reset (reset),
        .ctl   (if4.slave),
        .enbit (en4),
        .out   (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a one-cycle start from an idle cycle; returns at #1 into cycle T+1.
    task automatic launch(input int sel, input logic [2:0] o, input logic [31:0] d,
                          input logic [4:0] sv);
        @(posedge clk); #1;
        if (sel == 1) begin
            if1.op = o; if1.din = d; if1.s_value = sv; if1.start = 1'b1;
        end else begin
            if4.op = o; if4.din = d; if4.s_value = sv; if4.start = 1'b1;
        end
        @(posedge clk); #1;
        if1.start = 1'b0;
        if4.start = 1'b0;
    endtask

    // Step until done is seen (bounded); lat counts cycles since the accepting edge.
    task automatic wait_done(input int sel, input int lat0, output int lat, output logic [35:0] o);
        logic d;
        lat = lat0;
        d = (sel == 1) ? if1.done : if4.done;
        while (!d && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            d = (sel == 1) ? if1.done : if4.done;
        end
        o = (sel == 1) ? out1 : out4;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if1.busy); end
        checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", if1.done); end
        checks++; if (out1 !== 36'h0) begin errors++; $display("FAIL reset_out1 got=%h exp=0", out1); end
        checks++; if (out4 !== 36'h0) begin errors++; $display("FAIL reset_out4 got=%h exp=0", out4); end
        reset = 1'b0;
    endtask

    task automatic test_ror_basic;
        int lat;
        logic [35:0] o;
        launch(1, 3'b000, 32'h0000_0001, 5'd1);
        checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL ror_busy_t1 got=%b exp=1", if1.busy); end
        checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL ror_done_t1 got=%b exp=0", if1.done); end
        wait_done(1, 1, lat, o);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ror_latency got=%0d exp=2", lat); end
        checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL ror_busy_t2 got=%b exp=1", if1.busy); end
        checks++; if (o !== 36'hA_8000_0000) begin errors++; $display("FAIL ror_out got=%h exp=a80000000", o); end
        @(posedge clk); #1;
        checks++; if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++; $display("FAIL ror_idle_t3 got busy=%b done=%b exp 0/0", if1.busy, if1.done);
        end
    endtask

    task automatic test_step4;
        int lat;
        logic [35:0] o;
        launch(4, 3'b100, 32'h8000_0000, 5'd4);
        wait_done(4, 1, lat, o);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sar4_latency got=%0d exp=2", lat); end
        checks++; if (o !== 36'h8_F800_0000) begin errors++; $display("FAIL sar4_out got=%h exp=8f8000000", o); end
        launch(4, 3'b100, 32'h8000_0000, 5'd6);
        wait_done(4, 1, lat, o);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sar6_latency got=%0d exp=3", lat); end
        checks++; if (o !== 36'h8_FE00_0000) begin errors++; $display("FAIL sar6_out got=%h exp=8fe000000", o); end
        launch(4, 3'b000, 32'h1234_5678, 5'd6);
        wait_done(4, 1, lat, o);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ror6_latency got=%0d exp=3", lat); end
        checks++; if (o !== 36'hA_E048_D159) begin errors++; $display("FAIL ror6_out got=%h exp=ae048d159", o); end
    endtask

    task automatic test_shl_shr;
        int lat;
        logic [35:0] o;
        launch(1, 3'b011, 32'h4000_0000, 5'd1);
        wait_done(1, 1, lat, o);
        checks++; if (lat !== 2) begin errors++; $display("FAIL shl_latency got=%0d exp=2", lat); end
        checks++; if (o !== 36'h9_8000_0000) begin errors++; $display("FAIL shl_out got=%h exp=980000000", o); end
        launch(1, 3'b010, 32'h0000_0001, 5'd1);
        wait_done(1, 1, lat, o);
        checks++; if (o !== 36'h6_0000_0000) begin errors++; $display("FAIL shr_out got=%h exp=600000000", o); end
    endtask

    task automatic test_zero_and_pass;
        int lat;
        logic [35:0] o;
        launch(1, 3'b001, 32'h8000_0000, 5'd0);
        wait_done(1, 1, lat, o);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rol0_latency got=%0d exp=1", lat); end
        checks++; if (o !== 36'h8_8000_0000) begin errors++; $display("FAIL rol0_out got=%h exp=880000000", o); end
        launch(1, 3'b110, 32'h0000_0000, 5'd7);
        wait_done(1, 1, lat, o);
        checks++; if (lat !== 8) begin errors++; $display("FAIL pass_latency got=%0d exp=8", lat); end
        checks++; if (o !== 36'h4_0000_0000) begin errors++; $display("FAIL pass_out got=%h exp=400000000", o); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic [35:0] o;
        launch(1, 3'b000, 32'h0000_0001, 5'd31);
        repeat (4) begin @(posedge clk); #1; end
        if1.op = 3'b011; if1.din = 32'hFFFF_0000; if1.s_value = 5'd3; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        wait_done(1, 6, lat, o);
        checks++; if (lat !== 32) begin errors++; $display("FAIL max_latency got=%0d exp=32", lat); end
        checks++; if (o !== 36'h0_0000_0002) begin errors++; $display("FAIL ignore_out got=%h exp=000000002", o); end
        @(posedge clk); #1;
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL ignore_noqueue got busy=%b exp=0", if1.busy); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses;
        logic [35:0] o;
        launch(1, 3'b000, 32'h0000_0001, 5'd31);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", if1.busy); end
        checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", if1.done); end
        checks++; if (out1 !== 36'h0) begin errors++; $display("FAIL midrst_out got=%h exp=0", out1); end
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if1.done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_nodone got=%0d pulses exp=0", pulses); end
        launch(1, 3'b001, 32'h0000_0001, 5'd31);
        wait_done(1, 1, lat, o);
        checks++; if (lat !== 32) begin errors++; $display("FAIL after_rst_latency got=%0d exp=32", lat); end
        checks++; if (o !== 36'h8_8000_0000) begin errors++; $display("FAIL after_rst_out got=%h exp=880000000", o); end
    endtask

    task automatic test_enbit_done;
        int lat;
        logic [35:0] o;
        launch(4, 3'b011, 32'h4000_0000, 5'd1);
        wait_done(4, 1, lat, o);
        checks++; if (lat !== 2) begin errors++; $display("FAIL en_latency got=%0d exp=2", lat); end
        checks++; if (o !== 36'h9_8000_0000) begin errors++; $display("FAIL en_out_on got=%h exp=980000000", o); end
        en4 = 1'b0;
        #1;
        checks++; if (out4 !== {36{1'b1}}) begin errors++; $display("FAIL en_out_released got=%h exp=fffffffff", out4); end
        checks++; if (if4.done !== 1'b1) begin errors++; $display("FAIL en_done_kept got=%b exp=1", if4.done); end
        en4 = 1'b1;
        #1;
        checks++; if (out4 !== 36'h9_8000_0000) begin errors++; $display("FAIL en_out_restored got=%h exp=980000000", out4); end
        @(posedge clk); #1;
        checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL en_done_single got=%b exp=0", if4.done); end
        checks++; if (out4 !== 36'h9_8000_0000) begin errors++; $display("FAIL en_hold got=%h exp=980000000", out4); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] mask;
        logic [35:0] o;
        mask = '0;
        o = '0;
        @(posedge clk); #1;
        if1.op = 3'b010; if1.din = 32'h0000_00F0; if1.s_value = 5'd2; if1.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 7; c++) begin
            if (if1.done === 1'b1) mask[c] = 1'b1;
            if (c == 7) o = out1;
            @(posedge clk); #1;
        end
        if1.start = 1'b0;
        checks++; if (mask !== 9'b0_1000_1000) begin errors++; $display("FAIL b2b_done_cycles got=%b exp=010001000", mask); end
        checks++; if (o !== 36'h0_0000_003C) begin errors++; $display("FAIL b2b_out got=%h exp=00000003c", o); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        en1 = 1'b1;
        en4 = 1'b1;
        if1.start = 1'b0; if1.op = 3'b000; if1.din = '0; if1.s_value = '0;
        if4.start = 1'b0; if4.op = 3'b000; if4.din = '0; if4.s_value = '0;
        test_reset;
        test_ror_basic;
        test_step4;
        test_shl_shr;
        test_zero_and_pass;
        test_busy_ignore;
        test_reset_mid;
        test_enbit_done;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
